// File: rtl/dac_buf_pkg.sv
// Shared constants and helpers for the DAC sample buffer.
// Port A is byte-wide (2048 bytes). Port B is word-wide (512 x 32-bit stereo pairs).
package dac_buf_pkg;

   localparam int A_AW   = 11;
   localparam int B_AW   = 9;
   localparam int LANES  = 4;
   localparam int LANE_W = 8;
   localparam int B_DW   = LANES * LANE_W;

   // Turns the low byte-address bits into a one-hot lane write mask.
   function automatic logic [LANES-1:0] laneMask(input logic [1:0] lane);
      laneMask = 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/dac_buf_if.sv
// Bus bundle between the MCU write port / DAC read port and the sample buffer.
// The master drives the byte write port and the word read address.
// The slave (the buffer) returns the registered read word.
interface dac_buf_if;
   import dac_buf_pkg::*;

   logic              wea;
   logic [A_AW-1:0]   addra;
   logic [LANE_W-1:0] dina;
   logic [B_AW-1:0]   addrb;
   logic [B_DW-1:0]   doutb;

   modport master (output wea, output addra, output dina, output addrb, input doutb);
   modport slave  (input wea, input addra, input dina, input addrb, output doutb);
endinterface

// File: rtl/dac_buf_lane.sv
// One byte lane of the sample buffer: 512x8 simple dual-port RAM.
// It has one write port and one registered read port.
// A read and a write to the same entry on the same edge return the old byte.
module dac_buf_lane
   import dac_buf_pkg::*;
(
   input  logic              clkin,
   input  logic              reset,
   input  logic              i_we,
   input  logic [B_AW-1:0]   i_waddr,
   input  logic [LANE_W-1:0] i_wdata,
   input  logic [B_AW-1:0]   i_raddr,
   output logic [LANE_W-1:0] o_rdata
);

   logic [LANE_W-1:0] r_mem [0:(1<<B_AW)-1];
   logic [LANE_W-1:0] r_rdata;

   // The write port stays live during reset so the MCU can keep loading samples.
   always_ff @(posedge clkin) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read sees the pre-write contents, giving read-before-write on collisions.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dac_buf_dp.sv
// DAC sample buffer: byte-wide MCU write port, 32-bit stereo-pair read port.
// It is built from four byte lanes; lane L lands in doutb[8L+7:8L] (little-endian).
// Optional DAC_BUF_OUTREG_EN adds a second output register, giving 2-cycle read latency.
module dac_buf_dp
   import dac_buf_pkg::*;
(
   input  logic      clkin,
   input  logic      reset,
   dac_buf_if.slave  io_bus
);

   logic [LANES-1:0] w_mask;
   logic [B_DW-1:0]  w_ram;

   assign w_mask = laneMask(io_bus.addra[1:0]);

   for (genvar gL = 0; gL < LANES; gL++) begin : gLane
      dac_buf_lane uLane (
         .clkin   (clkin),
         .reset   (reset),
         .i_we    (io_bus.wea & w_mask[gL]),
         .i_waddr (io_bus.addra[A_AW-1:2]),
         .i_wdata (io_bus.dina),
         .i_raddr (io_bus.addrb),
         .o_rdata (w_ram[gL*LANE_W +: LANE_W])
      );
   end

`ifdef DAC_BUF_OUTREG_EN
   logic [B_DW-1:0] r_doutb2;

   // Second pipeline stage that retimes the RAM output; it clears together with the first stage.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_doutb2 <= '0;
      end else begin
         r_doutb2 <= w_ram;
      end
   end

   assign io_bus.doutb = r_doutb2;
`else
   assign io_bus.doutb = w_ram;
`endif

endmodule

// File: tb/tb_dac_buf_dp.sv
// Self-checking bench for dac_buf_dp.
// It uses a directed vector table plus an address sweep, checked through an expected-value queue.
// Each stimulus row pushes the word its read address should return. The queue delays that word
// by the read latency. When reset is asserted, the words still in flight are replaced with zero.
module tb_dac_buf_dp;
   import dac_buf_pkg::*;

`ifdef DAC_BUF_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic        rst;
      logic        we;
      logic [10:0] aa;
      logic [7:0]  da;
      logic [8:0]  ab;
      logic        chk;
      logic [31:0] expv;
      string       name;
   } vec_t;

   typedef struct {
      logic        chk;
      logic [31:0] val;
      string       name;
   } sb_t;

   logic clkin;
   logic reset;
   int   numChecks;
   int   numFails;
   vec_t vecs[$];
   sb_t  sbq[$];

   dac_buf_if bus ();

   dac_buf_dp dut (
      .clkin  (clkin),
      .reset  (reset),
      .io_bus (bus.slave)
   );

   // Free-running clock for both ports.
   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   function automatic logic [31:0] wordPat(input int n);
      logic [31:0] v;
      v = (32'h9E3779B9 * (n + 1)) ^ n;
      return v;
   endfunction

   function automatic void addVec(input logic rst, input logic we, input int aa, input logic [7:0] da,
                                  input int ab, input logic chk, input logic [31:0] expv, input string name);
      vec_t v;
      v.rst  = rst;
      v.we   = we;
      v.aa   = 11'(aa);
      v.da   = da;
      v.ab   = 9'(ab);
      v.chk  = chk;
      v.expv = expv;
      v.name = name;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input sb_t e);
      if (e.chk) begin
         numChecks++;
         if (bus.doutb !== e.val) begin
            numFails++;
            $display("[TB] FAIL %s: doutb=%h expected %h", e.name, bus.doutb, e.val);
         end
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      sb_t e;
      @(negedge clkin);
      reset     = v.rst;
      bus.wea   = v.we;
      bus.addra = v.aa;
      bus.dina  = v.da;
      bus.addrb = v.ab;
      e.chk  = v.chk;
      e.val  = v.rst ? 32'h0 : v.expv;
      e.name = v.name;
      sbq.push_back(e);
      @(posedge clkin);
      #1;
      if (v.rst) begin
         foreach (sbq[i]) sbq[i].val = 32'h0;
      end
      if (sbq.size() == 0) begin
         numChecks++;
         numFails++;
         $display("[TB] FAIL scoreboard: queue empty, expected an entry");
      end else begin
         e = sbq.pop_front();
         checkOutput(e);
      end
   endtask

   initial begin
      vec_t v;
      sb_t  e0;
      logic [31:0] w;
      numChecks = 0;
      numFails  = 0;
      reset     = 1'b1;
      bus.wea   = 1'b0;
      bus.addra = '0;
      bus.dina  = '0;
      bus.addrb = '0;

      for (int i = 0; i < LAT - 1; i++) begin
         e0.chk  = 1'b0;
         e0.val  = 32'h0;
         e0.name = "prefill";
         sbq.push_back(e0);
      end

      // rst we  addra data  addrb chk expected       name
      addVec(1, 0, 0,    8'h00, 0,   1, 32'h00000000, "resetA");
      addVec(1, 0, 0,    8'h00, 0,   1, 32'h00000000, "resetB");
      addVec(0, 1, 0,    8'h11, 0,   0, 32'h00000000, "packW0");
      addVec(0, 1, 1,    8'h22, 0,   0, 32'h00000000, "packW1");
      addVec(0, 1, 2,    8'h33, 0,   0, 32'h00000000, "packW2");
      addVec(0, 1, 3,    8'h44, 0,   0, 32'h00000000, "packW3");
      addVec(0, 0, 0,    8'h00, 0,   1, 32'h44332211, "lanePack");
      addVec(0, 1, 2,    8'hAA, 0,   1, 32'h44332211, "partialOld");
      addVec(0, 0, 0,    8'h00, 0,   1, 32'h44AA2211, "partialNew");
      addVec(0, 1, 2044, 8'h01, 0,   1, 32'h44AA2211, "topW0");
      addVec(0, 1, 2045, 8'h80, 0,   1, 32'h44AA2211, "topW1");
      addVec(0, 1, 2046, 8'hFF, 0,   1, 32'h44AA2211, "topW2");
      addVec(0, 1, 2047, 8'h7F, 0,   1, 32'h44AA2211, "topW3");
      addVec(0, 0, 0,    8'h00, 511, 1, 32'h7FFF8001, "topWord");
      addVec(0, 1, 20,   8'h00, 511, 1, 32'h7FFF8001, "zeroW5a");
      addVec(0, 1, 21,   8'h00, 511, 1, 32'h7FFF8001, "zeroW5b");
      addVec(0, 1, 22,   8'h00, 511, 1, 32'h7FFF8001, "zeroW5c");
      addVec(0, 1, 23,   8'h00, 511, 1, 32'h7FFF8001, "zeroW5d");
      addVec(0, 1, 20,   8'h5A, 5,   1, 32'h00000000, "collisionOld");
      addVec(0, 0, 0,    8'h00, 5,   1, 32'h0000005A, "collisionNew");
      addVec(0, 1, 2,    8'h33, 0,   1, 32'h44AA2211, "restoreW0");
      addVec(0, 1, 9,    8'h00, 0,   1, 32'h44332211, "zeroW2a");
      addVec(0, 1, 10,   8'h00, 0,   1, 32'h44332211, "zeroW2b");
      addVec(0, 1, 11,   8'h00, 0,   1, 32'h44332211, "zeroW2c");
      addVec(0, 0, 0,    8'h00, 0,   1, 32'h44332211, "preReset");
      addVec(1, 1, 8,    8'h99, 0,   1, 32'h00000000, "midResetA");
      addVec(1, 0, 0,    8'h00, 0,   1, 32'h00000000, "midResetB");
      addVec(0, 0, 0,    8'h00, 0,   1, 32'h44332211, "postReset");
      addVec(0, 0, 0,    8'h00, 2,   1, 32'h00000099, "resetWrite");

      $display("[TB] directed vectors: %0d rows, latency %0d", vecs.size(), LAT);
      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Fill every byte with a per-word pattern, then sweep the read port across all words.
      for (int n = 0; n < 2048; n++) begin
         w = wordPat(n >> 2);
         v.rst  = 1'b0;
         v.we   = 1'b1;
         v.aa   = 11'(n);
         v.da   = w[8*(n % 4) +: 8];
         v.ab   = 9'd0;
         v.chk  = 1'b0;
         v.expv = 32'h0;
         v.name = "sweepFill";
         applyStimulus(v);
      end
      for (int i = 0; i < 512; i++) begin
         v.rst  = 1'b0;
         v.we   = 1'b0;
         v.aa   = 11'd0;
         v.da   = 8'd0;
         v.ab   = 9'(i);
         v.chk  = 1'b1;
         v.expv = wordPat(i);
         v.name = $sformatf("sweep%0d", i);
         applyStimulus(v);
      end
      for (int i = 0; i < LAT - 1; i++) begin
         v.rst  = 1'b0;
         v.we   = 1'b0;
         v.ab   = 9'd0;
         v.chk  = 1'b0;
         v.name = "drain";
         applyStimulus(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
